// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII receive MAC.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SKIP,
        S_DATA,
        S_DROP
    } rx_state_t;

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_crc32_nib.sv
// CRC-32 engine consuming one MII nibble per cycle, bit 0 of the nibble first.
module eth_crc32_nib
    import eth_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic [3:0] data,
    output logic       match
);

    logic [31:0] crc;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc;
        for (int i = 0; i < 4; i++) begin
            crc_nxt = {crc_nxt[30:0], 1'b0} ^ ((crc_nxt[31] ^ data[i]) ? CRC_POLY : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    crc <= '1;
        else if (init) crc <= '1;
        else if (en)   crc <= crc_nxt;
    end

    // Running the FCS through the register leaves a fixed residue on a good frame.
    assign match = (crc == CRC_RESIDUE);

endmodule

// File: rtl/eth_rxethmac_p.sv
// MII receive MAC: nibble-to-byte assembly, preamble/SFD detect, header capture,
// address filter, IFG and length enforcement, CRC-32 check, per-frame status.
module eth_rxethmac_p
    import eth_rx_pkg::*;
#(
    parameter int BCNT_W        = 16,
    parameter int IFG_NIBBLES   = 24,
    parameter int DLY_CRC_BYTES = 4,
    parameter bit CRC_EN        = 1'b1
) (
    input  logic              MRxClk,
    input  logic              Reset_n,
    input  logic              MRxDV,
    input  logic              MRxErr,
    input  logic [3:0]        MRxD,
    input  logic [47:0]       MAC,
    input  logic [BCNT_W-1:0] MaxFL,
    input  logic [BCNT_W-1:0] MinFL,
    input  logic              r_IFG,
    input  logic              HugEn,
    input  logic              Pro,
    input  logic              r_Bro,
    input  logic              DlyCrcEn,
    output logic [7:0]        RxData,
    output logic              RxValid,
    output logic              RxStartFrm,
    output logic              RxEndFrm,
    output logic [47:0]       dst_mac_reg,
    output logic [47:0]       src_mac_reg,
    output logic [15:0]       length_reg,
    output logic [BCNT_W-1:0] ByteCnt,
    output logic              StatusValid,
    output logic              CrcError,
    output logic              TooLong,
    output logic              TooShort,
    output logic              AddressMiss,
    output logic              DribbleNibble,
    output logic              RxErrSeen
);

    localparam int IFG_W  = $clog2(IFG_NIBBLES + 2);
    localparam int SKIP_W = $clog2(2 * DLY_CRC_BYTES + 2);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(2 * DLY_CRC_BYTES - 1);

    rx_state_t         state, state_nxt;
    logic              armed;
    logic [IFG_W-1:0]  ifg_cnt;
    logic [SKIP_W-1:0] skip_cnt;
    logic              nib_hi;
    logic [3:0]        lo_nib;
    logic [7:0]        hold;
    logic              hold_vld, hold_first;
    logic              flush, stat_pend;
    logic              too_long_f, addr_miss, err_seen;
    logic              crc_match;

    logic              sfd, byte_done, frame_end, too_long_hit;
    logic              ifg_short;
    logic [7:0]        byte_new;
    logic [BCNT_W-1:0] cnt_inc;
    logic [47:0]       da_next;

    assign ifg_short = (ifg_cnt < IFG_W'(IFG_NIBBLES));
    assign byte_new  = {MRxD, lo_nib};
    assign cnt_inc   = (ByteCnt == '1) ? ByteCnt : ByteCnt + 1'b1;
    assign da_next   = {dst_mac_reg[39:0], byte_new};

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        sfd          = 1'b0;
        byte_done    = 1'b0;
        frame_end    = 1'b0;
        too_long_hit = 1'b0;
        case (state)
            // Until MRxDV has been seen low after reset we may be mid-frame.
            S_IDLE: begin
                if (MRxDV)
                    state_nxt = (!armed || (ifg_short && !r_IFG)) ? S_DROP : S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (!MRxDV) begin
                    state_nxt = S_IDLE;
                end else if (MRxD == 4'hD) begin
                    sfd       = 1'b1;
                    state_nxt = (DlyCrcEn && DLY_CRC_BYTES > 0) ? S_SKIP : S_DATA;
                end else if (MRxD != 4'h5) begin
                    state_nxt = S_DROP;
                end
            end
            S_SKIP: begin
                if (!MRxDV)                      state_nxt = S_IDLE;
                else if (skip_cnt == SKIP_LAST)  state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!MRxDV) begin
                    frame_end = 1'b1;
                    state_nxt = S_IDLE;
                end else if (nib_hi) begin
                    byte_done = 1'b1;
                    if (!HugEn && cnt_inc == MaxFL) begin
                        too_long_hit = 1'b1;
                        state_nxt    = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (!MRxDV) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    generate
        if (CRC_EN) begin : g_crc
            eth_crc32_nib u_crc (
                .clk   (MRxClk),
                .rst_n (Reset_n),
                .init  (sfd),
                .en    (state == S_DATA && MRxDV),
                .data  (MRxD),
                .match (crc_match)
            );
        end else begin : g_no_crc
            assign crc_match = 1'b1;
        end
    endgenerate

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            armed         <= 1'b0;
            ifg_cnt       <= IFG_W'(IFG_NIBBLES);
            skip_cnt      <= '0;
            nib_hi        <= 1'b0;
            lo_nib        <= '0;
            hold          <= '0;
            hold_vld      <= 1'b0;
            hold_first    <= 1'b0;
            flush         <= 1'b0;
            stat_pend     <= 1'b0;
            too_long_f    <= 1'b0;
            addr_miss     <= 1'b0;
            err_seen      <= 1'b0;
            RxData        <= '0;
            RxValid       <= 1'b0;
            RxStartFrm    <= 1'b0;
            RxEndFrm      <= 1'b0;
            dst_mac_reg   <= '0;
            src_mac_reg   <= '0;
            length_reg    <= '0;
            ByteCnt       <= '0;
            StatusValid   <= 1'b0;
            CrcError      <= 1'b0;
            TooLong       <= 1'b0;
            TooShort      <= 1'b0;
            AddressMiss   <= 1'b0;
            DribbleNibble <= 1'b0;
            RxErrSeen     <= 1'b0;
        end else begin
            RxValid     <= 1'b0;
            RxStartFrm  <= 1'b0;
            RxEndFrm    <= 1'b0;
            StatusValid <= 1'b0;

            if (!MRxDV) armed <= 1'b1;

            if (state != S_IDLE)                 ifg_cnt <= '0;
            else if (!MRxDV && ifg_short)        ifg_cnt <= ifg_cnt + 1'b1;

            if (sfd)                             skip_cnt <= '0;
            else if (state == S_SKIP && MRxDV)   skip_cnt <= skip_cnt + 1'b1;

            if (sfd) begin
                nib_hi     <= 1'b0;
                ByteCnt    <= '0;
                hold_vld   <= 1'b0;
                too_long_f <= 1'b0;
                addr_miss  <= 1'b0;
                err_seen   <= 1'b0;
            end

            if (state == S_DATA && MRxDV) begin
                nib_hi <= ~nib_hi;
                if (!nib_hi) lo_nib <= MRxD;
                if (MRxErr)  err_seen <= 1'b1;
            end

            // A byte is held back one byte-time so the last one can carry RxEndFrm.
            if (byte_done) begin
                ByteCnt <= cnt_inc;
                if (ByteCnt < BCNT_W'(6))       dst_mac_reg <= da_next;
                else if (ByteCnt < BCNT_W'(12)) src_mac_reg <= {src_mac_reg[39:0], byte_new};
                else if (ByteCnt < BCNT_W'(14)) length_reg  <= {length_reg[7:0], byte_new};
                if (ByteCnt == BCNT_W'(5))
                    addr_miss <= !(Pro || da_next == MAC || (da_next == BCAST_ADDR && !r_Bro));
                if (hold_vld) begin
                    RxValid    <= 1'b1;
                    RxData     <= hold;
                    RxStartFrm <= hold_first;
                end
                hold       <= byte_new;
                hold_vld   <= 1'b1;
                hold_first <= (ByteCnt == '0);
                if (too_long_hit) begin
                    flush      <= 1'b1;
                    too_long_f <= 1'b1;
                end
            end

            if (frame_end || flush) begin
                if (hold_vld) begin
                    RxValid    <= 1'b1;
                    RxData     <= hold;
                    RxStartFrm <= hold_first;
                    RxEndFrm   <= 1'b1;
                end
                hold_vld  <= 1'b0;
                flush     <= 1'b0;
                stat_pend <= 1'b1;
            end

            // A truncated frame has no meaningful FCS, so CrcError is masked.
            if (stat_pend) begin
                stat_pend     <= 1'b0;
                StatusValid   <= 1'b1;
                CrcError      <= CRC_EN && !too_long_f && !crc_match;
                TooLong       <= too_long_f;
                TooShort      <= (ByteCnt < MinFL);
                AddressMiss   <= addr_miss;
                DribbleNibble <= nib_hi;
                RxErrSeen     <= err_seen;
            end
        end
    end

endmodule

// File: tb/tb_eth_rxethmac_p.sv
// Directed bench for eth_rxethmac_p: frames built with a reference CRC-32,
// expected bytes/status queued at drive time and checked as the DUT emits them.
module tb_eth_rxethmac_p;

    localparam int BCNT_W = 16;
    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] SA    = 48'h00AA_BBCC_DDEE;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [5:0]  ALL   = 6'h3F;

    logic              MRxClk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              MRxDV = 1'b0, MRxErr = 1'b0;
    logic [3:0]        MRxD = '0;
    logic [47:0]       MAC = MAC_A;
    logic [BCNT_W-1:0] MaxFL = 16'd1518, MinFL = 16'd64;
    logic              r_IFG = 1'b0, HugEn = 1'b0, Pro = 1'b0, r_Bro = 1'b0, DlyCrcEn = 1'b0;
    logic [7:0]        RxData;
    logic              RxValid, RxStartFrm, RxEndFrm;
    logic [47:0]       dst_mac_reg, src_mac_reg;
    logic [15:0]       length_reg;
    logic [BCNT_W-1:0] ByteCnt;
    logic              StatusValid, CrcError, TooLong, TooShort, AddressMiss, DribbleNibble, RxErrSeen;

    eth_rxethmac_p #(.BCNT_W(BCNT_W)) dut (
        .MRxClk(MRxClk), .Reset_n(Reset_n), .MRxDV(MRxDV), .MRxErr(MRxErr), .MRxD(MRxD),
        .MAC(MAC), .MaxFL(MaxFL), .MinFL(MinFL), .r_IFG(r_IFG), .HugEn(HugEn), .Pro(Pro),
        .r_Bro(r_Bro), .DlyCrcEn(DlyCrcEn), .RxData(RxData), .RxValid(RxValid),
        .RxStartFrm(RxStartFrm), .RxEndFrm(RxEndFrm), .dst_mac_reg(dst_mac_reg),
        .src_mac_reg(src_mac_reg), .length_reg(length_reg), .ByteCnt(ByteCnt),
        .StatusValid(StatusValid), .CrcError(CrcError), .TooLong(TooLong), .TooShort(TooShort),
        .AddressMiss(AddressMiss), .DribbleNibble(DribbleNibble), .RxErrSeen(RxErrSeen)
    );

    always #5 MRxClk = ~MRxClk;

    typedef struct packed { logic [7:0] data; logic sof; logic eof; } exp_byte_t;
    typedef struct packed { logic [5:0] flags; logic [5:0] mask; logic [15:0] bcnt; } exp_stat_t;

    exp_byte_t  byte_q[$];
    exp_stat_t  stat_q[$];
    logic [7:0] frm[$];
    exp_byte_t  eb;
    exp_stat_t  es;
    int         total = 0, bad = 0, rx_cnt = 0, st_cnt = 0;
    int         r0, s0;
    bit         mon_ignore = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge MRxClk) begin
        if (Reset_n && RxValid) begin
            rx_cnt++;
            if (!mon_ignore) begin
                if (byte_q.size() == 0) check("rx_extra", 64'd1, 64'd0);
                else begin
                    eb = byte_q.pop_front();
                    check("rx_byte", 64'({RxData, RxStartFrm, RxEndFrm}), 64'({eb.data, eb.sof, eb.eof}));
                end
            end
        end
        if (Reset_n && StatusValid) begin
            st_cnt++;
            if (!mon_ignore) begin
                if (stat_q.size() == 0) check("status_extra", 64'd1, 64'd0);
                else begin
                    es = stat_q.pop_front();
                    check("status_flags",
                          64'({CrcError, TooLong, TooShort, AddressMiss, DribbleNibble, RxErrSeen} & es.mask),
                          64'(es.flags & es.mask));
                    check("status_bytecnt", 64'(ByteCnt), 64'(es.bcnt));
                end
            end
        end
    end

    // Header, random payload, then the standard reflected CRC-32 sent LSB byte first.
    task automatic make_frame(input logic [47:0] da, input int n);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(SA[47-8*i -: 8]);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 14; i < n - 4; i++) frm.push_back(8'($urandom));
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c ^= {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic nib(input logic dv, input logic [3:0] d, input logic er);
        @(negedge MRxClk);
        MRxDV = dv; MRxD = d; MRxErr = er;
    endtask

    task automatic preamble();
        repeat (15) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
    endtask

    task automatic drive_range(input int lo, input int hi, input int err_at);
        for (int i = lo; i < hi; i++) begin
            nib(1'b1, frm[i][3:0], i == err_at);
            nib(1'b1, frm[i][7:4], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) nib(1'b0, 4'h0, 1'b0);
    endtask

    task automatic send(input int n_out, input logic [5:0] f, input logic [5:0] m, input int bc,
                        input int err_at, input bit dribble, input int gap);
        for (int i = 0; i < n_out; i++)
            byte_q.push_back(exp_byte_t'{frm[i], i == 0, i == n_out - 1});
        stat_q.push_back(exp_stat_t'{f, m, 16'(bc)});
        preamble();
        drive_range(0, frm.size(), err_at);
        if (dribble) nib(1'b1, 4'hA, 1'b0);
        idle(gap);
    endtask

    task automatic drained(input string tag);
        check({tag, "_bytes_left"}, 64'(byte_q.size()), 64'd0);
        check({tag, "_status_left"}, 64'(stat_q.size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({RxData, RxValid, RxStartFrm, RxEndFrm, StatusValid, CrcError, TooLong,
                                   TooShort, AddressMiss, DribbleNibble, RxErrSeen, ByteCnt}), 64'd0);
        check({tag, "_dst"}, 64'(dst_mac_reg), 64'd0);
        check({tag, "_src"}, 64'(src_mac_reg), 64'd0);
        check({tag, "_len"}, 64'(length_reg), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge MRxClk);
        check_zero("reset");
        Reset_n = 1'b1;
        idle(5);

        // Good 64-byte frame to our address.
        make_frame(MAC_A, 64);
        send(64, 6'b000000, ALL, 64, -1, 1'b0, 30);
        drained("good");
        check("dst_mac", 64'(dst_mac_reg), 64'(MAC_A));
        check("src_mac", 64'(src_mac_reg), 64'(SA));
        check("length", 64'(length_reg), 64'h0800);

        // Corrupted last FCS byte.
        frm[63] = frm[63] ^ 8'h01;
        send(64, 6'b100000, ALL, 64, -1, 1'b0, 30);
        drained("crc_bad");

        // Broadcast rejected, then accepted in promiscuous mode.
        r_Bro = 1'b1;
        make_frame(BCAST, 64);
        send(64, 6'b000100, ALL, 64, -1, 1'b0, 30);
        drained("bcast_rej");
        check("bcast_dst", 64'(dst_mac_reg), 64'(BCAST));
        Pro = 1'b1;
        send(64, 6'b000000, ALL, 64, -1, 1'b0, 30);
        drained("bcast_pro");
        Pro = 1'b0; r_Bro = 1'b0;

        // Oversize frame truncated at MaxFL, then accepted whole with HugEn.
        make_frame(MAC_A, 1600);
        send(1518, 6'b010000, ALL, 1518, -1, 1'b0, 30);
        drained("too_long");
        HugEn = 1'b1;
        send(1600, 6'b000000, ALL, 1600, -1, 1'b0, 30);
        drained("huge");
        HugEn = 1'b0;

        // Back-to-back frames with a short gap.
        make_frame(MAC_A, 64);
        send(64, 6'b000000, ALL, 64, -1, 1'b0, 10);
        r0 = rx_cnt; s0 = st_cnt;
        preamble();
        drive_range(0, 64, -1);
        idle(30);
        check("ifg_drop_rx", 64'(rx_cnt - r0), 64'd0);
        check("ifg_drop_status", 64'(st_cnt - s0), 64'd0);
        drained("ifg_drop");
        r_IFG = 1'b1;
        send(64, 6'b000000, ALL, 64, -1, 1'b0, 10);
        send(64, 6'b000000, ALL, 64, -1, 1'b0, 30);
        drained("ifg_ok");
        r_IFG = 1'b0;

        // Short frame with a dribble nibble and an error pulse; CRC outcome left unchecked.
        make_frame(MAC_A, 60);
        send(60, 6'b001011, 6'b011111, 60, 20, 1'b1, 30);
        drained("short");

        // Reset in the middle of a frame, released while MRxDV is still high.
        make_frame(MAC_A, 64);
        mon_ignore = 1'b1;
        preamble();
        drive_range(0, 40, -1);
        Reset_n = 1'b0;
        drive_range(40, 43, -1);
        check_zero("midreset");
        Reset_n = 1'b1;
        r0 = rx_cnt; s0 = st_cnt;
        drive_range(43, 64, -1);
        idle(30);
        check("postreset_rx", 64'(rx_cnt - r0), 64'd0);
        check("postreset_status", 64'(st_cnt - s0), 64'd0);
        check_zero("postreset");
        mon_ignore = 1'b0;
        make_frame(MAC_A, 64);
        send(64, 6'b000000, ALL, 64, -1, 1'b0, 30);
        drained("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
